// File: rtl/rb_wb_pkg.sv
// Shared constants and the writeback entry type for the register-bank writer.
package rb_wb_pkg;

    localparam int RB_REGS = 16;
    localparam int DATA_W  = 16;
    localparam int REG_AW  = 4;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rb_wb_fifo.sv
// Small synchronous FIFO of writeback entries; pointers wrap modulo DEPTH.
module rb_wb_fifo
    import rb_wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  wb_entry_t     din_i,
    input  logic          pop_i,
    output wb_entry_t     head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW:0]   count_o
);

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if a caller misbehaves.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it maps onto plain RAM; the pointers guard validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/rb_wb.sv
// Writeback sequencer: arbitrates ALU/load results into a FIFO, drains one per
// cycle onto the register-bank write port and tracks pending writes.
module rb_wb
    import rb_wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid_in,
    output logic                 alu_ready_out,
    input  logic [REG_AW-1:0]    alu_rd_in,
    input  logic [DATA_W-1:0]    alu_d_in,
    input  logic                 mem_valid_in,
    output logic                 mem_ready_out,
    input  logic [REG_AW-1:0]    mem_rd_in,
    input  logic [DATA_W-1:0]    mem_d_in,
    input  logic                 issue_in,
    input  logic [REG_AW-1:0]    issue_rd_in,
    input  logic                 hold_in,
    output logic [RB_REGS-1:0]   busy_out,
    output logic                 rw_out,
    output logic [REG_AW-1:0]    rd_out,
    output logic [DATA_W-1:0]    d_out
);

    wb_entry_t           push_entry, head;
    logic                fifo_full, fifo_empty;
    logic [PW:0]         fifo_count;
    logic                mem_push, alu_push, push, pop;

    logic                rw_q, rw_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [RB_REGS-1:0]  busy_q, busy_d;

    // Readiness looks only at the registered fill level: no pass-through when full.
    assign mem_ready_out = !fifo_full;
    assign alu_ready_out = !fifo_full && !mem_valid_in;

    assign mem_push   = mem_valid_in && mem_ready_out;
    assign alu_push   = alu_valid_in && alu_ready_out;
    assign push       = mem_push || alu_push;
    assign push_entry = mem_push ? wb_entry_t'{rd: mem_rd_in, data: mem_d_in}
                                 : wb_entry_t'{rd: alu_rd_in, data: alu_d_in};
    assign pop        = !fifo_empty && !hold_in;

    rb_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rw_d   = pop;
        rd_d   = rd_q;
        d_d    = d_q;
        busy_d = busy_q;
        if (pop) begin
            rd_d              = head.rd;
            d_d               = head.data;
            busy_d[head.rd]   = 1'b0;
        end
        // A fresh issue to the register being retired means a newer write is pending.
        if (issue_in) busy_d[issue_rd_in] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q   <= 1'b0;
            rd_q   <= '0;
            d_q    <= '0;
            busy_q <= '0;
        end else begin
            rw_q   <= rw_d;
            rd_q   <= rd_d;
            d_q    <= d_d;
            busy_q <= busy_d;
        end
    end

    assign rw_out   = rw_q;
    assign rd_out   = rd_q;
    assign d_out    = d_q;
    assign busy_out = busy_q;

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= (PW+1)'(DEPTH));

endmodule

// File: tb/tb_rb_wb.sv
// Self-checking bench for rb_wb: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_rb_wb;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_valid_in, alu_ready_out;
    logic [3:0]  alu_rd_in;
    logic [15:0] alu_d_in;
    logic        mem_valid_in, mem_ready_out;
    logic [3:0]  mem_rd_in;
    logic [15:0] mem_d_in;
    logic        issue_in;
    logic [3:0]  issue_rd_in;
    logic        hold_in;
    logic [15:0] busy_out;
    logic        rw_out;
    logic [3:0]  rd_out;
    logic [15:0] d_out;

    rb_wb #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid_in  (alu_valid_in),
        .alu_ready_out (alu_ready_out),
        .alu_rd_in     (alu_rd_in),
        .alu_d_in      (alu_d_in),
        .mem_valid_in  (mem_valid_in),
        .mem_ready_out (mem_ready_out),
        .mem_rd_in     (mem_rd_in),
        .mem_d_in      (mem_d_in),
        .issue_in      (issue_in),
        .issue_rd_in   (issue_rd_in),
        .hold_in       (hold_in),
        .busy_out      (busy_out),
        .rw_out        (rw_out),
        .rd_out        (rd_out),
        .d_out         (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        av;
        logic [3:0]  ard;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] md;
        logic        iss;
        logic [3:0]  ird;
        logic        hold;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        e_alu_r;
        logic        e_mem_r;
        logic        e_rw;
        logic [3:0]  e_rd;
        logic [15:0] e_d;
        logic [15:0] e_busy;
    } vec_t;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
    } ment_t;

    // Reference model state: pending writes in arrival order plus port/scoreboard view.
    ment_t       mq[$];
    logic        m_rw;
    logic [3:0]  m_rd;
    logic [15:0] m_d;
    logic [15:0] m_busy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rw   = 1'b0;
        m_rd   = '0;
        m_d    = '0;
        m_busy = '0;
    endtask

    // One cycle: drive, check readys, clock, advance model, check outputs.
    task automatic step(input stim_t s, output logic ar, output logic mr);
        int    cnt;
        bit    full;
        ment_t e;
        alu_valid_in = s.av;  alu_rd_in = s.ard;  alu_d_in = s.ad;
        mem_valid_in = s.mv;  mem_rd_in = s.mrd;  mem_d_in = s.md;
        issue_in     = s.iss; issue_rd_in = s.ird; hold_in = s.hold;
        #1;
        cnt  = mq.size();
        full = (cnt >= DEPTH);
        ar = alu_ready_out;
        mr = mem_ready_out;
        chk("mem_ready", {31'd0, mr}, {31'd0, !full});
        chk("alu_ready", {31'd0, ar}, {31'd0, !full && !s.mv});
        @(posedge clk);
        if (cnt > 0 && !s.hold) begin
            e = mq.pop_front();
            m_rw = 1'b1;
            m_rd = e.rd;
            m_d  = e.data;
            m_busy[e.rd] = 1'b0;
        end else begin
            m_rw = 1'b0;
        end
        if (!full && s.mv) mq.push_back('{rd: s.mrd, data: s.md});
        else if (!full && s.av) mq.push_back('{rd: s.ard, data: s.ad});
        if (s.iss) m_busy[s.ird] = 1'b1;
        #1;
        chk("rw_out",   {31'd0, rw_out}, {31'd0, m_rw});
        chk("rd_out",   {28'd0, rd_out}, {28'd0, m_rd});
        chk("d_out",    {16'd0, d_out},  {16'd0, m_d});
        chk("busy_out", {16'd0, busy_out}, {16'd0, m_busy});
    endtask

    localparam stim_t IDLE = '0;

    vec_t  tbl [11];
    stim_t s;
    logic  ar, mr;
    logic [3:0]  got_rd[$];
    logic [15:0] got_d[$];
    int    first_rw, last_rw;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 av    ard    ad        mv    mrd    md        iss   ird    hold   alu_r mem_r rw    rd     d         busy
        tbl[0]  = '{'{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0}, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{IDLE,                                                            1'b1, 1'b1, 1'b1, 4'd3, 16'hBEEF, 16'h0000};
        tbl[2]  = '{IDLE,                                                            1'b1, 1'b1, 1'b0, 4'd3, 16'hBEEF, 16'h0000};
        tbl[3]  = '{'{1'b1, 4'd1, 16'h0001, 1'b1, 4'd2, 16'h0002, 1'b0, 4'd0, 1'b0}, 1'b0, 1'b1, 1'b0, 4'd3, 16'hBEEF, 16'h0000};
        tbl[4]  = '{'{1'b1, 4'd1, 16'h0001, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0}, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0002, 16'h0000};
        tbl[5]  = '{IDLE,                                                            1'b1, 1'b1, 1'b1, 4'd1, 16'h0001, 16'h0000};
        tbl[6]  = '{IDLE,                                                            1'b1, 1'b1, 1'b0, 4'd1, 16'h0001, 16'h0000};
        tbl[7]  = '{'{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0}, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0001, 16'h0080};
        tbl[8]  = '{'{1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0}, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0001, 16'h0080};
        tbl[9]  = '{'{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0}, 1'b1, 1'b1, 1'b1, 4'd7, 16'h7777, 16'h0080};
        tbl[10] = '{IDLE,                                                            1'b1, 1'b1, 1'b0, 4'd7, 16'h7777, 16'h0080};

        alu_valid_in = 0; alu_rd_in = 0; alu_d_in = 0;
        mem_valid_in = 0; mem_rd_in = 0; mem_d_in = 0;
        issue_in = 0; issue_rd_in = 0; hold_in = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_rw",   {31'd0, rw_out},   32'd0);
        chk("reset_rd",   {28'd0, rd_out},   32'd0);
        chk("reset_d",    {16'd0, d_out},    32'd0);
        chk("reset_busy", {16'd0, busy_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table: latency, priority, scoreboard set-wins.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].s, ar, mr);
            chk($sformatf("tbl%0d_alu_ready", i), {31'd0, ar},       {31'd0, tbl[i].e_alu_r});
            chk($sformatf("tbl%0d_mem_ready", i), {31'd0, mr},       {31'd0, tbl[i].e_mem_r});
            chk($sformatf("tbl%0d_rw", i),        {31'd0, rw_out},   {31'd0, tbl[i].e_rw});
            chk($sformatf("tbl%0d_rd", i),        {28'd0, rd_out},   {28'd0, tbl[i].e_rd});
            chk($sformatf("tbl%0d_d", i),         {16'd0, d_out},    {16'd0, tbl[i].e_d});
            chk($sformatf("tbl%0d_busy", i),      {16'd0, busy_out}, {16'd0, tbl[i].e_busy});
            $display("vec %0d: rw=%0b rd=%0d d=%h busy=%h", i, rw_out, rd_out, d_out, busy_out);
        end

        // Fill under hold: four accepted, fifth refused, then drain in order.
        for (int k = 0; k < 5; k++) begin
            s = IDLE; s.av = 1'b1; s.ard = 4'(k); s.ad = 16'(k); s.hold = 1'b1;
            step(s, ar, mr);
            chk($sformatf("hold_push%0d_ready", k), {31'd0, ar}, {31'd0, k < 4});
            $display("hold push %0d: ready=%0b", k, ar);
        end
        begin
            bit pending = 1'b1;
            got_rd.delete();
            for (int c = 0; c < 10; c++) begin
                s = IDLE;
                if (pending) begin s.av = 1'b1; s.ard = 4'd4; s.ad = 16'd4; end
                step(s, ar, mr);
                if (pending && ar) pending = 1'b0;
                if (rw_out) got_rd.push_back(rd_out);
                $display("hold drain %0d: rw=%0b rd=%0d", c, rw_out, rd_out);
            end
            chk("hold_drain_count", got_rd.size(), 5);
            for (int k = 0; k < 5 && k < got_rd.size(); k++)
                chk($sformatf("hold_drain_rd%0d", k), {28'd0, got_rd[k]}, k);
        end

        // Async reset with entries parked and a busy bit set.
        for (int k = 0; k < 3; k++) begin
            s = IDLE; s.av = 1'b1; s.ard = 4'(k + 8); s.ad = 16'hA000 + 16'(k);
            s.iss = 1'b1; s.ird = 4'd9; s.hold = 1'b1;
            step(s, ar, mr);
            $display("pre-reset push %0d", k);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_rw",   {31'd0, rw_out},   32'd0);
        chk("async_rst_rd",   {28'd0, rd_out},   32'd0);
        chk("async_rst_d",    {16'd0, d_out},    32'd0);
        chk("async_rst_busy", {16'd0, busy_out}, 32'd0);
        $display("async reset: rw=%0b rd=%0d d=%h busy=%h", rw_out, rd_out, d_out, busy_out);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(IDLE, ar, mr);
            chk($sformatf("post_rst_rw%0d", c), {31'd0, rw_out}, 32'd0);
            $display("post-reset %0d: rw=%0b", c, rw_out);
        end

        // Back-to-back stream wrapping the pointers several times.
        got_d.delete();
        first_rw = -1; last_rw = -1;
        for (int c = 0; c < 13; c++) begin
            s = IDLE;
            if (c < 10) begin s.av = 1'b1; s.ard = 4'(c); s.ad = 16'(c); end
            step(s, ar, mr);
            if (rw_out) begin
                got_d.push_back(d_out);
                if (first_rw < 0) first_rw = c;
                last_rw = c;
            end
            $display("stream %0d: rw=%0b d=%h", c, rw_out, d_out);
        end
        chk("stream_count", got_d.size(), 10);
        chk("stream_no_gap", last_rw - first_rw, 9);
        for (int k = 0; k < 10 && k < got_d.size(); k++)
            chk($sformatf("stream_d%0d", k), {16'd0, got_d[k]}, k);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            s.av   = ($urandom_range(0, 1) == 1);
            s.ard  = 4'($urandom_range(0, 15));
            s.ad   = 16'($urandom);
            s.mv   = ($urandom_range(0, 2) == 0);
            s.mrd  = 4'($urandom_range(0, 15));
            s.md   = 16'($urandom);
            s.iss  = ($urandom_range(0, 2) == 0);
            s.ird  = 4'($urandom_range(0, 15));
            s.hold = ($urandom_range(0, 3) == 0);
            step(s, ar, mr);
            $display("rand %0d: rw=%0b rd=%0d d=%h busy=%h", c, rw_out, rd_out, d_out, busy_out);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rb_wb.md
Name: rb_wb

Overview:
- Register-bank writeback sequencer: the writer side of the register bank's single write port.
- Accepts results from the ALU and the load path over valid/ready handshakes, arbitrates between them and buffers them in a small FIFO.
- Drains one entry per cycle onto the bank write port (data, write enable, write address = rs_in[11:8] of the bank).
- Maintains a 16-bit pending-write scoreboard so decode can stall on registers with a write still in flight.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2).
- DATA_W, 16, result/register width.
- REG_AW, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid_in  in  1  ALU result valid.
- alu_ready_out  out  1  ALU result accepted when valid&ready.
- alu_rd_in  in  4  ALU destination register.
- alu_d_in  in  16  ALU result data.
- mem_valid_in  in  1  load result valid.
- mem_ready_out  out  1  load result accepted when valid&ready.
- mem_rd_in  in  4  load destination register.
- mem_d_in  in  16  load data.
- issue_in  in  1  decode issued an instruction that will write issue_rd_in.
- issue_rd_in  in  4  destination of issued instruction.
- hold_in  in  1  write port borrowed (loader/debug); no drain while 1.
- busy_out  out  16  bit r = 1: register r has a pending write.
- rw_out  out  1  bank write enable (to rw_in).
- rd_out  out  4  bank write address (to rs_in[11:8]).
- d_out  out  16  bank write data (to d_in).

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied, count=0.
  - busy_out=0, rw_out=0, rd_out=0, d_out=0.
  - Entries in flight are discarded; no write is issued after release.
- Ready logic (combinational from registered count only):
  - mem_ready_out = (count < DEPTH).
  - alu_ready_out = (count < DEPTH) && !mem_valid_in.
  - Load has fixed priority; at most one enqueue per cycle.
  - No pass-through when full: a pop in the same cycle does not raise ready.
- Enqueue: on a clk edge with a completed handshake, {rd, data} is written at the tail.
- Drain (registered):
  - Each edge with count>0 and hold_in=0: pop the head into rd_out/d_out and set rw_out=1.
  - Otherwise rw_out=0; rd_out/d_out hold their last value.
  - rw_out is never high for more than one cycle per entry.
- Simultaneous enqueue and pop: count unchanged; FIFO order preserved; an entry pushed into an empty FIFO pops at the next edge, never at the same edge.
- Latency: handshake at edge N, hold_in=0 → rw_out=1 during the cycle after edge N+1, so the bank captures at edge N+2. Throughput is 1 write/cycle.
- Full: count==DEPTH → both readys 0; inputs must hold valid (standard valid/ready, no drop).
- Wrap-around: head/tail pointers are REG_AW-independent, log2(DEPTH) bits, modulo DEPTH; count is log2(DEPTH)+1 bits.
- Scoreboard:
  - issue_in sets busy[issue_rd_in] at the edge.
  - An edge that sets rw_out=1 clears busy[head.rd].
  - Same register set and cleared at the same edge: set wins (a newer write is pending).
  - Setting an already-busy bit is a no-op.
- Same destination twice in the FIFO: writes are committed in FIFO order, so the last value wins in the bank.

Decomposition:
- mycpu_pkg additions:
  - constants RB_REGS=16, DATA_W=16, REG_AW=4.
  - typedef wb_entry_t packed struct {logic [REG_AW-1:0] rd; logic [DATA_W-1:0] data;}.
- One sub-module: rb_wb_fifo.
  - Synchronous FIFO of wb_entry_t, parameter DEPTH.
  - Ports push/pop/full/empty/count.
  - Same async active-low reset.
- Arbitration, drain register and scoreboard stay in rb_wb.

Test Plan:
- Reset, then alu_valid_in=1, alu_rd_in=3, alu_d_in=16'hBEEF for one cycle → alu_ready_out=1; two edges later rw_out=1, rd_out=3, d_out=16'hBEEF for exactly one cycle.
- alu and mem valid together (alu rd=1/16'h0001, mem rd=2/16'h0002) → mem accepted first (alu_ready_out=0 that cycle); writes appear as rd=2 then rd=1 on consecutive cycles.
- hold_in=1 while pushing 5 ALU results (rd 0..4) → 4 accepted, then alu_ready_out=0; release hold_in → rw_out high 4 consecutive cycles, rd_out 0,1,2,3, then the 5th is accepted and drained.
- issue_in=1, issue_rd_in=7 → busy_out=16'h0080. Later the rd=7 write pops while issue_in=1, rd=7 at the same edge → busy_out stays 16'h0080.
- Fill 3 entries with hold_in=1, pulse rst_n=0 mid-cycle → outputs 0 immediately; after release no rw_out pulse occurs.
- Wrap: stream 10 back-to-back results with d = index → d_out sequence 0..9 in order, no gaps, no duplicates.
